var_seq_monitor: RTL and testbench

Cycle-based monitor that sits directly downstream of the stimulus bench and consumes its `varA`..`varD` control lines. It detects rising edges and checks that they arrive in the order A→B→C→D within a bounded window. It reports completed sequences, ordering and timeout errors, and keeps event counters that the bench can print and check.

---
 rtl/var_seq_monitor.sv | 167 ++++++++++++++++
 tb/tb_var_seq_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/var_seq_monitor.sv
// var_seq_monitor: watches varA..varD for rising edges and checks that they
// arrive in the order A->B->C->D. Reports completed sequences (seq_done),
// aborted sequences (seq_err + err_code) and keeps a saturating varB rise
// counter and a wrapping completed-sequence counter.
//
// Optional feature: define VAR_SEQ_MON_TIMEOUT_EN to compile in the
// inter-edge timer and the TIMEOUT error. Without it a WAIT state may be
// held indefinitely and err_code never reads 2.
module var_seq_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16   // legal range 2..255
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic             varA,
  input  logic             varB,
  input  logic             varC,
  input  logic             varD,
  input  logic             clr,
  output logic             seq_done,
  output logic             seq_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    WAIT_C = 2'd2,
    WAIT_D = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ORDER   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

  // Bit order for all edge vectors: {D, C, B, A}.
  logic [3:0] cur;
  logic [3:0] prev_q;
  logic [3:0] rise;

  state_t     state_q, state_d;
  logic       done_d, err_d;
  logic [1:0] code_d;
  logic       accept;
  logic [3:0] exp_mask;
  logic       timeout_hit;

  assign cur  = {varD, varC, varB, varA};
  assign rise = cur & ~prev_q;

  // Previous-value registers track the live inputs every cycle.
  // NOTE: prev_q is deliberately left out of reset so a line that is already
  // high when reset releases is not mistaken for a fresh rise.
  always_ff @(posedge clk) begin
    prev_q <= cur;
  end

`ifdef VAR_SEQ_MON_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] timer_q;

  // Inter-edge timer: clears on accepted edges and outside a sequence,
  // otherwise counts cycles spent waiting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer_q <= '0;
    end else if (accept || state_q == IDLE || state_d == IDLE) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 8'd1;
    end
  end

  // This cycle is the TIMEOUT-th since the last accepted edge.
  assign timeout_hit = (timer_q == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and pulse decode for the sequence FSM.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = err_code;
    accept   = 1'b0;
    exp_mask = 4'b0000;

    unique case (state_q)
      IDLE:    exp_mask = 4'b0001;
      WAIT_B:  exp_mask = 4'b0010;
      WAIT_C:  exp_mask = 4'b0100;
      WAIT_D:  exp_mask = 4'b1000;
      default: exp_mask = 4'b0000;
    endcase

    if (state_q == IDLE) begin
      // Only A opens a sequence; stray B/C/D rises are ignored here.
      if (rise[0]) begin
        state_d = WAIT_B;
        accept  = 1'b1;
      end
    end else if (rise == exp_mask) begin
      // The expected rise, alone: advance (or complete on D).
      accept = 1'b1;
      if (state_q == WAIT_D) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = state_t'(state_q + 2'd1);
      end
    end else if (rise != 4'b0000) begin
      // Any other rise, including a re-rise of A or the expected rise
      // accompanied by another, aborts the sequence.
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = ERR_ORDER;
    end else if (timeout_hit) begin
      // Only reached when no edge arrived, so an edge suppresses timeout.
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end

  // FSM state and registered status outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      seq_done <= 1'b0;
      seq_err  <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      seq_done <= done_d;
      seq_err  <= err_d;
      err_code <= code_d;
    end
  end

  // Event counters: rise_cnt saturates, match_cnt wraps, clr wins.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      rise_cnt  <= '0;
      match_cnt <= '0;
    end else begin
      if (rise[1] && rise_cnt != {CNT_W{1'b1}}) begin
        rise_cnt <= rise_cnt + 1'b1;
      end
      if (done_d) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_var_seq_monitor.sv
// Directed testbench for var_seq_monitor. A main instance (CNT_W=8,
// TIMEOUT=16) exercises the sequence FSM; a second instance with CNT_W=2
// exercises rise_cnt saturation and clr priority.
module tb_var_seq_monitor;

  logic clk = 1'b0;
  logic rst;
  logic a, b, c, d, clr;
  logic seq_done, seq_err;
  logic [1:0] err_code, state;
  logic [7:0] rise_cnt, match_cnt;

  logic b2, clr2;
  logic seq_done2, seq_err2;
  logic [1:0] err_code2, state2;
  logic [1:0] rise_cnt2, match_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  var_seq_monitor #(.CNT_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .varA(a), .varB(b), .varC(c), .varD(d), .clr(clr),
    .seq_done(seq_done), .seq_err(seq_err), .err_code(err_code),
    .rise_cnt(rise_cnt), .match_cnt(match_cnt), .state(state)
  );

  var_seq_monitor #(.CNT_W(2), .TIMEOUT(16)) dut2 (
    .clk(clk), .rst(rst),
    .varA(1'b0), .varB(b2), .varC(1'b0), .varD(1'b0), .clr(clr2),
    .seq_done(seq_done2), .seq_err(seq_err2), .err_code(err_code2),
    .rise_cnt(rise_cnt2), .match_cnt(match_cnt2), .state(state2)
  );

  // One clock edge, then settle before sampling outputs.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic va, input logic vb, input logic vc, input logic vd);
    a = va; b = vb; c = vc; d = vd;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; b2 = 1'b0; clr2 = 1'b0;
    drive(0, 0, 0, 0);

    // Reset for one cycle, then release.
    cyc();
    rst = 1'b1;
    check("reset_state", 32'(state), 0);
    check("reset_done", 32'(seq_done), 0);
    check("reset_err", 32'(seq_err), 0);
    check("reset_code", 32'(err_code), 0);
    check("reset_rise", 32'(rise_cnt), 0);
    check("reset_match", 32'(match_cnt), 0);
    cyc();
    check("idle_state", 32'(state), 0);

    // Full A,B,C,D sequence on consecutive cycles.
    drive(1, 0, 0, 0); cyc(); check("seq_a_state", 32'(state), 1);
    drive(1, 1, 0, 0); cyc(); check("seq_b_state", 32'(state), 2);
    drive(1, 1, 1, 0); cyc(); check("seq_c_state", 32'(state), 3);
    check("seq_c_nodone", 32'(seq_done), 0);
    drive(1, 1, 1, 1); cyc(); check("seq_d_state", 32'(state), 0);
    check("seq_d_done", 32'(seq_done), 1);
    check("seq_d_noerr", 32'(seq_err), 0);
    check("seq_match", 32'(match_cnt), 1);
    check("seq_rise", 32'(rise_cnt), 1);
    cyc(); check("seq_done_1cyc", 32'(seq_done), 0);
    drive(0, 0, 0, 0); cyc();

    // Order error: A then C.
    drive(1, 0, 0, 0); cyc(); check("ord_a_state", 32'(state), 1);
    drive(0, 0, 1, 0); cyc();
    check("ord_err", 32'(seq_err), 1);
    check("ord_code", 32'(err_code), 1);
    check("ord_state", 32'(state), 0);
    check("ord_nodone", 32'(seq_done), 0);
    cyc();
    check("ord_err_1cyc", 32'(seq_err), 0);
    check("ord_code_held", 32'(err_code), 1);
    // B rise while idle is counted but ignored by the FSM.
    drive(0, 1, 0, 0); cyc();
    check("idle_b_rise", 32'(rise_cnt), 2);
    check("idle_b_state", 32'(state), 0);
    drive(0, 0, 0, 0); cyc();

    // Re-rise of A inside a sequence is an order error.
    drive(1, 0, 0, 0); cyc(); check("rera_state1", 32'(state), 1);
    drive(0, 0, 0, 0); cyc(); check("rera_hold", 32'(state), 1);
    drive(1, 0, 0, 0); cyc();
    check("rera_err", 32'(seq_err), 1);
    check("rera_state0", 32'(state), 0);
    drive(0, 0, 0, 0); cyc();

    // Timeout: A, then nothing for 16 cycles.
    drive(1, 0, 0, 0); cyc(); check("tmo_a_state", 32'(state), 1);
    for (int i = 0; i < 15; i++) cyc();
    check("tmo_pre_state", 32'(state), 1);
    check("tmo_pre_err", 32'(seq_err), 0);
    cyc();
`ifdef VAR_SEQ_MON_TIMEOUT_EN
    check("tmo_err", 32'(seq_err), 1);
    check("tmo_code", 32'(err_code), 2);
    check("tmo_state", 32'(state), 0);
`else
    check("notmo_state", 32'(state), 1);
    check("notmo_err", 32'(seq_err), 0);
    check("notmo_code", 32'(err_code), 1);
`endif

    // Reset mid-sequence in WAIT_C with varA held high across reset.
    drive(0, 0, 0, 0);
    rst = 1'b0; cyc(); rst = 1'b1; cyc();
    drive(1, 0, 0, 0); cyc(); check("mid_a_state", 32'(state), 1);
    drive(1, 1, 0, 0); cyc(); check("mid_b_state", 32'(state), 2);
    rst = 1'b0; cyc();
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_noerr", 32'(seq_err), 0);
    check("mid_rst_code", 32'(err_code), 0);
    check("mid_rst_rise", 32'(rise_cnt), 0);
    rst = 1'b1; cyc();
    check("mid_nophantom", 32'(state), 0);
    cyc();
    check("mid_nophantom2", 32'(state), 0);
    check("mid_noerr2", 32'(seq_err), 0);

    // Pulsed sequence followed immediately by a new A (back-to-back).
    drive(0, 0, 0, 0); cyc();
    drive(1, 0, 0, 0); cyc();
    drive(0, 1, 0, 0); cyc();
    drive(0, 0, 1, 0); cyc();
    drive(0, 0, 0, 1); cyc();
    check("b2b_done", 32'(seq_done), 1);
    check("b2b_match", 32'(match_cnt), 1);
    drive(1, 0, 0, 0); cyc();
    check("b2b_state", 32'(state), 1);
    check("b2b_done_off", 32'(seq_done), 0);
    // Expected B together with C in WAIT_B is an order error.
    drive(0, 1, 1, 0); cyc();
    check("dual_err", 32'(seq_err), 1);
    check("dual_code", 32'(err_code), 1);
    check("dual_state", 32'(state), 0);
    check("dual_rise", 32'(rise_cnt), 2);
    // clr zeroes the main counters without disturbing the FSM.
    drive(0, 0, 0, 0); clr = 1'b1; cyc(); clr = 1'b0;
    check("clr_match", 32'(match_cnt), 0);
    check("clr_rise", 32'(rise_cnt), 0);
    check("clr_code", 32'(err_code), 1);

    // CNT_W=2 instance: 5 B rises saturate at 3, then clr with a rise wins.
    for (int i = 0; i < 5; i++) begin
      b2 = 1'b1; cyc();
      b2 = 1'b0; cyc();
    end
    check("sat_rise", 32'(rise_cnt2), 3);
    check("sat_state", 32'(state2), 0);
    b2 = 1'b1; clr2 = 1'b1; cyc();
    check("sat_clr", 32'(rise_cnt2), 0);
    b2 = 1'b0; clr2 = 1'b0; cyc();
    b2 = 1'b1; cyc();
    check("sat_after_clr", 32'(rise_cnt2), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
